// File: rtl/ppu_pkg.sv
// Shared definitions for the PPU controller: input-FSM state encoding,
// PPU mode encodings and default frame geometry.
package ppu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } in_state_e;

    localparam logic [2:0] MODE_PASS   = 3'd0;
    localparam logic [2:0] MODE_INV    = 3'd1;
    localparam logic [2:0] MODE_GRAY   = 3'd2;
    localparam logic [2:0] MODE_MIRROR = 3'd3;
    localparam logic [2:0] MODE_TILE   = 3'd4;
    localparam logic [2:0] MODE_FIXED  = 3'd5;

    localparam int DEF_H_PIX   = 32;
    localparam int DEF_V_LINES = 32;

endpackage

// File: rtl/ppu_rr_arb2.sv
// Two-requester round-robin arbiter (host vs pattern loader).
// Ports:
//   clk, rst        clock, async active-high reset
//   en_i            grants are only issued while enabled
//   req_host_i      host request
//   req_ld_i        loader request
//   upd_i           a grant was consumed this cycle; remember its owner
//   gnt_host_o      host grant (combinational)
//   gnt_ld_o        loader grant (combinational)
module ppu_rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic req_host_i,
    input  logic req_ld_i,
    input  logic upd_i,
    output logic gnt_host_o,
    output logic gnt_ld_o
);

    // 1 = loader owned the last grant; reset to loader so the host wins first.
    logic last_ld_q;

    always_comb begin
        gnt_host_o = en_i && req_host_i && (!req_ld_i || last_ld_q);
        gnt_ld_o   = en_i && req_ld_i && (!req_host_i || !last_ld_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_ld_q <= 1'b1;
        end else if (upd_i) begin
            last_ld_q <= gnt_ld_o;
        end
    end

endmodule

// File: rtl/ppu_ctrl.sv
// PPU sequencing controller.
// Arbitrates host / pattern-loader bytes into the PPU single-pulse strobe/ack
// input, drains the PPU strobe/ack output into a registered valid/ready pixel
// stream, counts pixels to find frame boundaries, and at each boundary pulses
// ppu_sync, applies the pending mode and bumps frame_cnt.
// Ports:
//   clk, rst                         clock, async active-high reset
//   mode_wr, mode_wdata              pending-mode write
//   host_data/valid/ready            host byte stream
//   ld_data/valid/ready              pattern-loader byte stream
//   ppu_data_i, ppu_stb_i, ppu_ack_i byte into PPU (strobe/ack)
//   ppu_data_o, ppu_stb_o, ppu_ack_o byte out of PPU (strobe/ack)
//   ppu_sync, ppu_mode               frame sync pulse, active mode
//   pix_data/valid/ready, pix_last   pixel stream, last-of-frame flag
//   frame_cnt                        completed frames (wraps)
module ppu_ctrl
    import ppu_pkg::*;
#(
    parameter int H_PIX   = DEF_H_PIX,
    parameter int V_LINES = DEF_V_LINES,
    parameter int FRAME_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode_wr,
    input  logic [2:0]         mode_wdata,
    input  logic [7:0]         host_data,
    input  logic               host_valid,
    output logic               host_ready,
    input  logic [7:0]         ld_data,
    input  logic               ld_valid,
    output logic               ld_ready,
    output logic [7:0]         ppu_data_i,
    output logic               ppu_stb_i,
    input  logic               ppu_ack_i,
    input  logic [7:0]         ppu_data_o,
    input  logic               ppu_stb_o,
    output logic               ppu_ack_o,
    output logic               ppu_sync,
    output logic [2:0]         ppu_mode,
    output logic [7:0]         pix_data,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic               pix_last,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam int HW = (H_PIX > 1) ? $clog2(H_PIX) : 1;
    localparam int VW = (V_LINES > 1) ? $clog2(V_LINES) : 1;
    localparam logic [HW-1:0] H_LAST = HW'(H_PIX - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_LINES - 1);

    // ---------------- input side ----------------
    in_state_e  state_q, state_d;
    logic       gnt_host, gnt_ld, xfer;
    logic [7:0] byte_q;

    ppu_rr_arb2 u_arb (
        .clk        (clk),
        .rst        (rst),
        .en_i       (state_q == ST_IDLE),
        .req_host_i (host_valid),
        .req_ld_i   (ld_valid),
        .upd_i      (xfer),
        .gnt_host_o (gnt_host),
        .gnt_ld_o   (gnt_ld)
    );

    // A grant is only raised for a valid requester, so a grant is a transfer.
    assign xfer = gnt_host | gnt_ld;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (xfer)      state_d = ST_SEND;
            ST_SEND:                state_d = ST_WAIT;
            ST_WAIT: if (ppu_ack_i) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            byte_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            if (xfer) byte_q <= gnt_host ? host_data : ld_data;
        end
    end

    assign host_ready = gnt_host;
    assign ld_ready   = gnt_ld;
    assign ppu_data_i = byte_q;
    assign ppu_stb_i  = (state_q == ST_SEND);

    // ---------------- output side ----------------
    logic [7:0]         pix_data_q;
    logic               pix_valid_q, pix_last_q, ack_q, sync_q;
    logic [2:0]         mode_q, mode_pend_q;
    logic [FRAME_W-1:0] frame_q;
    logic [HW-1:0]      h_q;
    logic [VW-1:0]      v_q;
    logic               pix_load, frame_end;

    // The cycle after an ack the PPU is still dropping its strobe, so ignore it.
    assign pix_load  = ppu_stb_o && !ack_q && (!pix_valid_q || pix_ready);
    assign frame_end = pix_load && (h_q == H_LAST) && (v_q == V_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_data_q  <= 8'h00;
            pix_valid_q <= 1'b0;
            pix_last_q  <= 1'b0;
            ack_q       <= 1'b0;
            sync_q      <= 1'b0;
            mode_q      <= MODE_PASS;
            mode_pend_q <= MODE_PASS;
            frame_q     <= '0;
            h_q         <= '0;
            v_q         <= '0;
        end else begin
            ack_q  <= pix_load;
            sync_q <= frame_end;

            if (pix_load) begin
                pix_data_q  <= ppu_data_o;
                pix_valid_q <= 1'b1;
                pix_last_q  <= frame_end;
            end else if (pix_ready) begin
                pix_valid_q <= 1'b0;
                pix_last_q  <= 1'b0;
            end

            if (mode_wr) mode_pend_q <= mode_wdata;

            if (frame_end) begin
                // A write on the boundary edge bypasses straight into the mode.
                mode_q  <= mode_wr ? mode_wdata : mode_pend_q;
                frame_q <= frame_q + FRAME_W'(1);
                h_q     <= '0;
                v_q     <= '0;
            end else if (pix_load) begin
                if (h_q == H_LAST) begin
                    h_q <= '0;
                    v_q <= (v_q == V_LAST) ? '0 : v_q + VW'(1);
                end else begin
                    h_q <= h_q + HW'(1);
                end
            end
        end
    end

    assign pix_data  = pix_data_q;
    assign pix_valid = pix_valid_q;
    assign pix_last  = pix_last_q;
    assign ppu_ack_o = ack_q;
    assign ppu_sync  = sync_q;
    assign ppu_mode  = mode_q;
    assign frame_cnt = frame_q;

endmodule
